// File: rtl/piso_shift_register.sv
`default_nettype none
// ============================================================================
// Module      : piso_shift_register
// Description : Parallel-in serial-out shift register. Takes WIDTH-bit words
//               through a valid/ready handshake and serialises them onto
//               s_out one bit per shift_en tick. Consecutive words stream
//               with no idle cycle in between.
// Revision    : 1.0 - initial release
// ============================================================================
module piso_shift_register #(
    parameter int WIDTH     = 4,
    parameter bit MSB_FIRST = 1'b1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             preset,
    input  logic             shift_en,
    input  logic             load_valid,
    output logic             load_ready,
    input  logic [WIDTH-1:0] p_in,
    output logic             s_out,
    output logic             s_valid,
    output logic             frame_start,
    output logic             frame_done,
    output logic             busy
);

    localparam int                 c_CNT_W = $clog2(WIDTH);
    localparam logic [c_CNT_W-1:0] c_LAST  = c_CNT_W'(WIDTH - 1);
    localparam logic [c_CNT_W-1:0] c_ONE   = c_CNT_W'(1);

    localparam logic [0:0] c_IDLE  = 1'b0;
    localparam logic [0:0] c_SHIFT = 1'b1;

    logic [0:0]         r_state;
    logic [WIDTH-1:0]   r_shift_reg;
    logic [c_CNT_W-1:0] r_bit_cnt;

    logic [WIDTH-1:0]   w_shifted;
    logic               w_line_bit;
    logic               w_busy;
    logic               w_last_bit;
    logic               w_accept;

    // Shift direction and line tap depend on the bit order; the vacated
    // position always fills with 0.
    generate
        if (MSB_FIRST) begin : g_msb_first
            assign w_shifted  = {r_shift_reg[WIDTH-2:0], 1'b0};
            assign w_line_bit = r_shift_reg[WIDTH-1];
        end else begin : g_lsb_first
            assign w_shifted  = {1'b0, r_shift_reg[WIDTH-1:1]};
            assign w_line_bit = r_shift_reg[0];
        end
    endgenerate

    // Handshake and frame decode. load_ready opens on the final bit's tick
    // so the next word can follow without a gap.
    always_comb begin
        w_busy      = (r_state == c_SHIFT);
        w_last_bit  = w_busy && (r_bit_cnt == c_LAST);
        load_ready  = !preset && ((r_state == c_IDLE) || (w_last_bit && shift_en));
        w_accept    = load_valid && load_ready;
        busy        = w_busy;
        s_valid     = w_busy;
        s_out       = w_busy && w_line_bit;
        frame_start = w_busy && (r_bit_cnt == '0);
        frame_done  = w_last_bit && shift_en;
    end

    // Framing FSM and datapath: preset beats accept, accept beats shift.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= c_IDLE;
            r_shift_reg <= '0;
            r_bit_cnt   <= '0;
        end else if (preset) begin
            r_state     <= c_IDLE;
            r_shift_reg <= '1;
            r_bit_cnt   <= '0;
        end else if (w_accept) begin
            r_state     <= c_SHIFT;
            r_shift_reg <= p_in;
            r_bit_cnt   <= '0;
        end else if (w_busy && shift_en) begin
            r_shift_reg <= w_shifted;
            if (w_last_bit) begin
                r_state   <= c_IDLE;
                r_bit_cnt <= '0;
            end else begin
                r_bit_cnt <= r_bit_cnt + c_ONE;
            end
        end
    end

endmodule
`default_nettype wire
